// File: rtl/rsi_sched_if.sv
// rsi_sched_if: request, engine and result signals of the RSI scheduler
//   i_req_valid/i_req_price/o_req_ready  per-channel price handshake (ingress)
//   o_eng_* / i_eng_rsi*                 shared RSI engine drive and result
//   o_rsi/o_rsi_ch/o_rsi_valid/i_rsi_ready  tagged result to the consumer
//   o_timeout/o_busy                     status
interface rsi_sched_if #(parameter int M = 4, parameter int N = 14);
  localparam int CW = $clog2(M);
  logic [M-1:0] i_req_valid;
  logic [M-1:0][15:0] i_req_price;
  logic [M-1:0] o_req_ready;
  logic o_eng_en;
  logic o_eng_valid_price;
  logic [15:0] o_eng_curr_price;
  logic [N-1:0][15:0] o_eng_prices;
  logic [15:0] i_eng_rsi;
  logic i_eng_rsi_valid;
  logic [15:0] o_rsi;
  logic [CW-1:0] o_rsi_ch;
  logic o_rsi_valid;
  logic i_rsi_ready;
  logic o_timeout;
  logic o_busy;
  modport slave (
    input i_req_valid, i_req_price, i_eng_rsi, i_eng_rsi_valid, i_rsi_ready,
    output o_req_ready, o_eng_en, o_eng_valid_price, o_eng_curr_price, o_eng_prices,
    output o_rsi, o_rsi_ch, o_rsi_valid, o_timeout, o_busy
  );
  modport master (
    output i_req_valid, i_req_price, i_eng_rsi, i_eng_rsi_valid, i_rsi_ready,
    input o_req_ready, o_eng_en, o_eng_valid_price, o_eng_curr_price, o_eng_prices,
    input o_rsi, o_rsi_ch, o_rsi_valid, o_timeout, o_busy
  );
endinterface

// File: rtl/rsi_sched.sv
// rsi_sched: round-robin time-multiplexing of one RSI engine across M price channels
//   i_clk, i_rst (async, active-low), bus: rsi_sched_if.slave carrying the price
//   request handshake, engine drive/result and tagged result output
module rsi_sched #(
  parameter int M = 4,
  parameter int N = 14,
  parameter int TIMEOUT = 64
) (
  input logic i_clk,
  input logic i_rst,
  rsi_sched_if.slave bus
);
  localparam int CW = $clog2(M);
  localparam int FW = $clog2(N + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, FIRE, WAIT, OUT, COMMIT} state_t;
  state_t state;
  logic [CW-1:0] rr_ptr, ch_reg, g, c;
  logic found, tmo;
  logic [15:0] p_reg;
  logic [M-1:0][N-1:0][15:0] win;
  logic [M-1:0][FW-1:0] fill;
  logic [TW-1:0] wcnt;
  // first requesting channel at or after rr_ptr, wrapping mod M
  always_comb begin
    g = '0;
    c = '0;
    found = 1'b0;
    for (int i = 0; i < M; i++) begin
      c = CW'((int'(rr_ptr) + i) % M);
      if (!found && bus.i_req_valid[c]) begin
        g = c;
        found = 1'b1;
      end
    end
  end
  // a result strobe on the last wait cycle takes priority over the timeout
  assign tmo = state == WAIT && !bus.i_eng_rsi_valid && wcnt == TW'(TIMEOUT - 1);
  assign bus.o_req_ready = (i_rst && state == IDLE && found) ? M'(1) << g : '0;
  assign bus.o_eng_en = state == FIRE;
  assign bus.o_eng_valid_price = state == FIRE;
  assign bus.o_eng_curr_price = p_reg;
  assign bus.o_eng_prices = win[ch_reg];
  assign bus.o_rsi_valid = state == OUT;
  assign bus.o_timeout = tmo;
  assign bus.o_busy = state != IDLE;
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      ch_reg <= '0;
      p_reg <= '0;
      win <= '0;
      fill <= '0;
      wcnt <= '0;
      bus.o_rsi <= '0;
      bus.o_rsi_ch <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          p_reg <= bus.i_req_price[g];
          ch_reg <= g;
          state <= fill[g] == FW'(N) ? FIRE : COMMIT;
        end
        FIRE: begin
          wcnt <= '0;
          state <= WAIT;
        end
        WAIT: begin
          wcnt <= wcnt + 1'b1;
          if (bus.i_eng_rsi_valid) begin
            bus.o_rsi <= bus.i_eng_rsi;
            bus.o_rsi_ch <= ch_reg;
            state <= OUT;
          end else if (tmo) state <= COMMIT;
        end
        OUT: if (bus.i_rsi_ready) state <= COMMIT;
        COMMIT: begin
          // oldest entry falls out at index 0, newest price enters at N-1
          win[ch_reg] <= {p_reg, win[ch_reg][N-1:1]};
          fill[ch_reg] <= fill[ch_reg] == FW'(N) ? fill[ch_reg] : fill[ch_reg] + 1'b1;
          rr_ptr <= ch_reg == CW'(M - 1) ? '0 : ch_reg + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rsi_sched.sv
// tb_rsi_sched: directed self-checking bench for rsi_sched
module tb_rsi_sched;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fires = 0;
  rsi_sched_if #(.M(4), .N(14)) bus ();
  rsi_sched #(.M(4), .N(14), .TIMEOUT(64)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.o_eng_en) fires <= fires + 1;
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input int ch, input logic [15:0] p);
    bus.i_req_valid[ch] = 1'b1;
    bus.i_req_price[ch] = p;
    #1;
    for (int k = 0; k < 200 && !bus.o_req_ready[ch]; k++) tick();
    chk("grant", bus.o_req_ready[ch], 1);
    tick();
    bus.i_req_valid[ch] = 1'b0;
  endtask
  task automatic respond(input int lat, input logic [15:0] v);
    repeat (lat) tick();
    bus.i_eng_rsi_valid = 1'b1;
    bus.i_eng_rsi = v;
    tick();
    bus.i_eng_rsi_valid = 1'b0;
  endtask
  logic [13:0][15:0] ew;
  int f0, t0, tp, exp_ch;
  bit seen;
  initial begin
    bus.i_req_valid = '0;
    bus.i_req_price = '0;
    bus.i_eng_rsi = '0;
    bus.i_eng_rsi_valid = 1'b0;
    bus.i_rsi_ready = 1'b1;
    tick();
    tick();
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_ready", bus.o_req_ready, 0);
    chk("rst_rsi_valid", bus.o_rsi_valid, 0);
    chk("rst_eng_en", bus.o_eng_en, 0);
    chk("rst_prices", bus.o_eng_prices, 0);
    rst = 1'b1;
    tick();
    for (int k = 1; k <= 14; k++) send(0, 16'(k << 8));
    chk("warm_no_fire", fires, 0);
    send(0, 16'h0F00);
    for (int k = 0; k < 14; k++) ew[k] = 16'((k + 1) << 8);
    chk("warm_eng_en", bus.o_eng_en, 1);
    chk("warm_valid_price", bus.o_eng_valid_price, 1);
    chk("warm_curr", bus.o_eng_curr_price, 16'h0F00);
    chk("warm_window", bus.o_eng_prices, ew);
    respond(1, 16'h3210);
    chk("warm_rsi_valid", bus.o_rsi_valid, 1);
    chk("warm_rsi", bus.o_rsi, 16'h3210);
    chk("warm_rsi_ch", bus.o_rsi_ch, 0);
    chk("warm_fires", fires, 1);
    tick();
    tick();
    for (int k = 0; k < 14; k++) send(2, 16'h2000 + 16'(k));
    bus.i_req_price[0] = 16'h1000;
    bus.i_req_price[2] = 16'h3000;
    bus.i_req_valid = 4'b0101;
    tp = 0;
    for (int i = 0; i < 4; i++) begin
      exp_ch = (i % 2 == 1) ? 2 : 0;
      #1;
      for (int k = 0; k < 50 && bus.o_req_ready == 0; k++) tick();
      chk("rr_grant", bus.o_req_ready, 4'(1 << exp_ch));
      if (i > 0) chk("rr_gap", cyc - tp, 7);
      tp = cyc;
      tick();
      chk("rr_curr", bus.o_eng_curr_price, exp_ch == 0 ? 16'h1000 : 16'h3000);
      respond(3, 16'h0500 + 16'(i));
      chk("rr_rsi_ch", bus.o_rsi_ch, exp_ch);
      chk("rr_rsi", bus.o_rsi, 16'h0500 + 16'(i));
      tick();
      tick();
    end
    bus.i_req_valid = '0;
    bus.i_rsi_ready = 1'b0;
    bus.i_req_valid[1] = 1'b1;
    bus.i_req_price[1] = 16'h1111;
    send(0, 16'h1800);
    respond(2, 16'h0BB0);
    for (int k = 0; k < 10; k++) begin
      chk("bp_valid", bus.o_rsi_valid, 1);
      chk("bp_rsi", bus.o_rsi, 16'h0BB0);
      chk("bp_ch", bus.o_rsi_ch, 0);
      chk("bp_ready", bus.o_req_ready, 0);
      tick();
    end
    bus.i_rsi_ready = 1'b1;
    tick();
    chk("bp_drop", bus.o_rsi_valid, 0);
    chk("bp_commit_busy", bus.o_busy, 1);
    chk("bp_commit_ready", bus.o_req_ready, 0);
    tick();
    chk("bp_next_grant", bus.o_req_ready, 4'b0010);
    tick();
    bus.i_req_valid[1] = 1'b0;
    tick();
    for (int k = 0; k < 12; k++) ew[k] = 16'h2002 + 16'(k);
    ew[12] = 16'h3000;
    ew[13] = 16'h3000;
    send(2, 16'h4000);
    chk("to_window", bus.o_eng_prices, ew);
    t0 = cyc;
    seen = 0;
    for (int k = 0; k < 100 && !bus.o_timeout; k++) begin
      tick();
      if (bus.o_rsi_valid) seen = 1;
    end
    chk("to_timeout", bus.o_timeout, 1);
    chk("to_gap", cyc - t0, 64);
    chk("to_hold_window", bus.o_eng_prices, ew);
    chk("to_hold_curr", bus.o_eng_curr_price, 16'h4000);
    chk("to_no_rsi", seen, 0);
    tick();
    chk("to_pulse_end", bus.o_timeout, 0);
    chk("to_no_rsi_after", bus.o_rsi_valid, 0);
    tick();
    for (int k = 0; k < 11; k++) ew[k] = 16'h2003 + 16'(k);
    ew[11] = 16'h3000;
    ew[12] = 16'h3000;
    ew[13] = 16'h4000;
    send(2, 16'h5000);
    chk("to_shifted", bus.o_eng_prices, ew);
    respond(1, 16'h7777);
    chk("to_next_rsi", bus.o_rsi, 16'h7777);
    tick();
    tick();
    bus.i_eng_rsi_valid = 1'b1;
    bus.i_eng_rsi = 16'h1234;
    tick();
    bus.i_eng_rsi_valid = 1'b0;
    chk("stale_valid", bus.o_rsi_valid, 0);
    chk("stale_rsi", bus.o_rsi, 16'h7777);
    chk("stale_busy", bus.o_busy, 0);
    send(0, 16'hAAAA);
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", bus.o_busy, 0);
    chk("mid_rst_rsi", bus.o_rsi, 0);
    chk("mid_rst_prices", bus.o_eng_prices, 0);
    chk("mid_rst_curr", bus.o_eng_curr_price, 0);
    chk("mid_rst_outs", {bus.o_eng_en, bus.o_rsi_valid, bus.o_timeout, bus.o_rsi_ch}, 0);
    tick();
    rst = 1'b1;
    f0 = fires;
    for (int k = 0; k < 14; k++) send(0, 16'h0A00 + 16'(k));
    chk("post_rst_no_fire", fires - f0, 0);
    send(0, 16'hBEEF);
    for (int k = 0; k < 14; k++) ew[k] = 16'h0A00 + 16'(k);
    chk("post_rst_fire", bus.o_eng_en, 1);
    chk("post_rst_window", bus.o_eng_prices, ew);
    respond(2, 16'h4242);
    chk("post_rst_rsi", bus.o_rsi, 16'h4242);
    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rsi_sched.md
Name: rsi_sched

Overview:
- Time-multiplexes one shared RSI engine (the rs + rsi datapath pair, G_POLARITY and N matched) between M independent price channels.
- Each channel keeps an N-deep sliding price window. Price updates are accepted per channel through a valid/ready handshake and granted round-robin.
- Once a channel's window is full, each new price fires one engine computation. The result is returned tagged with its channel number.
- Sits between the market-data ingress and the RSI engine. The engine is instantiated outside this block.

Parameters:
M, 4, number of price channels (2..8)
N, 14, RSI window length; must equal engine N
TIMEOUT, 64, max cycles to wait for i_eng_rsi_valid after firing
CW, $clog2(M), channel index width (derived, not overridable)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-low
i_req_valid  in  M  per-channel price valid
i_req_price  in  M x uq8_8_t  per-channel price
o_req_ready  out  M  per-channel accept; at most one bit high
o_eng_en  out  1  engine enable pulse
o_eng_valid_price  out  1  engine price-valid pulse (same cycle as o_eng_en)
o_eng_curr_price  out  uq8_8_t  current price to engine
o_eng_prices  out  N x uq8_8_t  window to engine; index 0 oldest
i_eng_rsi  in  uq8_8_t  engine result
i_eng_rsi_valid  in  1  engine result strobe
o_rsi  out  uq8_8_t  result to consumer
o_rsi_ch  out  CW  channel of o_rsi
o_rsi_valid  out  1  result valid; held until accepted
i_rsi_ready  in  1  consumer accept
o_timeout  out  1  one-cycle pulse on engine timeout
o_busy  out  1  high in any state except IDLE

Behaviour:
- Reset (i_rst low, asynchronous): state IDLE; rr_ptr=0; all windows 0; all fill counters 0; every output 0. Reset mid-transaction discards the transaction completely.
- FSM states: IDLE, FIRE, WAIT, OUT, COMMIT.
- IDLE:
  - Grant g = first c with i_req_valid[c]=1, searching c = rr_ptr, rr_ptr+1, … mod M.
  - o_req_ready[g]=1 combinationally in IDLE only. The handshake completes that cycle.
  - On handshake, latch price into p_reg and g into ch_reg.
  - Next state FIRE if fill[g]==N, else COMMIT. With no valid request, stay in IDLE.
- FIRE (1 cycle):
  - o_eng_en=1 and o_eng_valid_price=1.
  - o_eng_curr_price = p_reg; o_eng_prices = window[ch_reg], pre-shift.
  - Clear the wait counter; go to WAIT.
- WAIT:
  - o_eng_prices and o_eng_curr_price are held stable.
  - Wait counter increments every cycle.
  - On i_eng_rsi_valid: capture i_eng_rsi into o_rsi and ch_reg into o_rsi_ch; go to OUT.
  - Else, if counter reaches TIMEOUT-1: pulse o_timeout and go to COMMIT. No result is produced.
  - i_eng_rsi_valid arriving on the timeout cycle wins.
- OUT:
  - o_rsi_valid=1; o_rsi and o_rsi_ch held stable.
  - When i_rsi_ready=1, drop o_rsi_valid next cycle and go to COMMIT.
- COMMIT (1 cycle):
  - window[ch_reg] shifts: entry k takes entry k+1, entry N-1 takes p_reg.
  - fill[ch_reg] = min(fill+1, N).
  - rr_ptr = (ch_reg+1) mod M; go to IDLE.
- Price acceptance and ordering:
  - A price enters the window even when the engine timed out.
  - Per-channel order is preserved; every accepted price is committed exactly once.
- i_eng_rsi_valid in any state other than WAIT is ignored (stale or spurious).
- No new request is granted outside IDLE.
- Minimum transaction times:
  - Warm-up price: 2 cycles (IDLE, COMMIT).
  - Full window with engine latency L and zero-wait consumer: L+4 cycles accept-to-next-grant.
- o_eng_en and o_eng_valid_price are high for exactly one cycle per fire.

Test Plan:
1. Warm-up: channel 0 sends 0x0100,0x0200,…,0x0F00 (15 prices) → no o_eng_en for the first 14; the 15th fires with o_eng_prices[0..13]=0x0100..0x0E00 and o_eng_curr_price=0x0F00; o_rsi_ch=0.
2. Round-robin: windows full, i_req_valid=4'b0101 held high, engine latency 3, i_rsi_ready=1 → grants alternate 0,2,0,2; o_rsi_ch follows the same sequence; channels 1 and 3 never get ready.
3. Backpressure: i_rsi_ready low for 10 cycles after o_rsi_valid → o_rsi_valid, o_rsi and o_rsi_ch stable; o_req_ready all zero; commit occurs one cycle after i_rsi_ready rises.
4. Timeout: engine never asserts valid, TIMEOUT=64 → o_timeout pulses exactly 64 cycles after FIRE; no o_rsi_valid; the next fire on that channel shows its window shifted by one (price committed).
5. Stale strobe and reset: pulse i_eng_rsi_valid in IDLE → no o_rsi_valid. Assert i_rst low during WAIT → all outputs 0 immediately; after release, the channel needs 14 new prices before firing again.
